scic_io_port: RTL and testbench

- Parametrised switch/LED I/O peripheral for the SCIC system; it generalises the fixed 4-switch/4-LED path.
- Synchronises and debounces a WIDTH-bit switch bus and latches a "new value" flag with overflow detection. The CPU can therefore poll for fresh input instead of relying on fixed instruction timing.
- Drives a WIDTH-bit LED register written by the CPU, or mirrors the debounced switches when mirror mode is enabled.
- Sits between the SCIC core's I/O bus and the board pins.

---
 rtl/scic_io_pkg.sv | 26 ++
 rtl/scic_debounce.sv | 65 ++++++
 rtl/scic_io_port.sv | 110 +++++++++++
 tb/tb_scic_io_port.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/scic_io_pkg.sv
// Shared constants for the SCIC switch/LED I/O port.
package scic_io_pkg;

   // Register select on io_addr
   localparam logic ADDR_DATA   = 1'b0;
   localparam logic ADDR_STATUS = 1'b1;

   // Status word bit positions
   localparam int unsigned ST_NEW    = 0;
   localparam int unsigned ST_OVF    = 1;
   localparam int unsigned ST_MIRROR = 2;
   localparam int unsigned ST_BITS   = 3;

   // Assemble the status word in bit-index order {mirror, overflow, new}
   function automatic logic [ST_BITS-1:0] pack_status(input logic mirror,
                                                      input logic ovf,
                                                      input logic nw);
      logic [ST_BITS-1:0] st;
      st            = '0;
      st[ST_NEW]    = nw;
      st[ST_OVF]    = ovf;
      st[ST_MIRROR] = mirror;
      return st;
   endfunction

endpackage

// File: rtl/scic_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for a switch bus.
module scic_debounce #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] switches_i,
   output logic [WIDTH-1:0] stable_o,
   output logic             update_c
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync2_q, sync2_d;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Candidate tracking and stability counting; update fires on the accepting edge
   always_comb begin
      sync1_d  = switches_i;
      sync2_d  = sync1_q;
      cand_d   = cand_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      update_c = 1'b0;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cand_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = cand_q;
            cnt_d    = '0;
            update_c = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         cand_q   <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         cand_q   <= cand_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/scic_io_port.sv
// SCIC switch/LED peripheral: debounced switch input with new/overflow flags,
// CPU-written LED register with optional switch mirroring.
module scic_io_port
   import scic_io_pkg::*;
#(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] switches,
   output logic [WIDTH-1:0] LEDs,
   input  logic             io_addr,
   input  logic             io_rd,
   input  logic             io_wr,
   input  logic [WIDTH-1:0] io_wdata,
   output logic [WIDTH-1:0] io_rdata,
   output logic             sw_ready
);

   logic [WIDTH-1:0] stable;
   logic             update_c;

   logic             new_q, new_d;
   logic             ovf_q, ovf_d;
   logic             mirror_q, mirror_d;
   logic [WIDTH-1:0] led_reg_q, led_reg_d;
   logic [WIDTH-1:0] leds_q, leds_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;

   logic             data_rd_c;
   logic             stat_rd_c;

   scic_debounce #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clock      (clock),
      .reset      (reset),
      .switches_i (switches),
      .stable_o   (stable),
      .update_c   (update_c)
   );

   // Flag handshake, register file and LED source selection
   always_comb begin
      new_d     = new_q;
      ovf_d     = ovf_q;
      mirror_d  = mirror_q;
      led_reg_d = led_reg_q;
      rdata_d   = rdata_q;
      data_rd_c = io_rd && (io_addr == ADDR_DATA);
      stat_rd_c = io_rd && (io_addr == ADDR_STATUS);

      // A fresh value always wins over a consuming read
      if (update_c) begin
         new_d = 1'b1;
      end else if (data_rd_c) begin
         new_d = 1'b0;
      end

      // Overflow only when an unread value is overwritten
      if (update_c && new_q && !data_rd_c) begin
         ovf_d = 1'b1;
      end else if (stat_rd_c) begin
         ovf_d = 1'b0;
      end

      // Reads return pre-edge state
      if (data_rd_c) begin
         rdata_d = stable;
      end else if (stat_rd_c) begin
         rdata_d = WIDTH'(pack_status(mirror_q, ovf_q, new_q));
      end

      if (io_wr) begin
         if (io_addr == ADDR_DATA) begin
            led_reg_d = io_wdata;
         end else begin
            mirror_d = io_wdata[0];
         end
      end

      leds_d = mirror_q ? stable : led_reg_q;
   end

   // Registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         new_q     <= 1'b0;
         ovf_q     <= 1'b0;
         mirror_q  <= 1'b0;
         led_reg_q <= '0;
         leds_q    <= '0;
         rdata_q   <= '0;
      end else begin
         new_q     <= new_d;
         ovf_q     <= ovf_d;
         mirror_q  <= mirror_d;
         led_reg_q <= led_reg_d;
         leds_q    <= leds_d;
         rdata_q   <= rdata_d;
      end
   end

   assign LEDs     = leds_q;
   assign io_rdata = rdata_q;
   assign sw_ready = new_q;

endmodule

// File: tb/tb_scic_io_port.sv
// Self-checking bench for scic_io_port: default 4-bit instance plus an 8-bit,
// single-sample debounce instance; read results are scoreboarded.
module tb_scic_io_port;

   logic       clock;
   logic       reset;

   logic [3:0] sw4, leds4, wdata4, rdata4;
   logic       addr4, rd4, wr4, rdy4;

   logic [7:0] sw8, leds8, wdata8, rdata8;
   logic       addr8, rd8, wr8, rdy8;

   logic [7:0] exp_q[$];
   int         tests;
   int         fails;

   scic_io_port #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) u_dut4 (
      .clock    (clock),
      .reset    (reset),
      .switches (sw4),
      .LEDs     (leds4),
      .io_addr  (addr4),
      .io_rd    (rd4),
      .io_wr    (wr4),
      .io_wdata (wdata4),
      .io_rdata (rdata4),
      .sw_ready (rdy4)
   );

   scic_io_port #(.WIDTH(8), .DEBOUNCE_CYCLES(1)) u_dut8 (
      .clock    (clock),
      .reset    (reset),
      .switches (sw8),
      .LEDs     (leds8),
      .io_addr  (addr8),
      .io_rd    (rd8),
      .io_wr    (wr8),
      .io_wdata (wdata8),
      .io_rdata (rdata8),
      .sw_ready (rdy8)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // One bus cycle on the selected instance; read results go through the scoreboard
   task automatic bus_op(input bit sel, input logic rd, input logic wr, input logic addr,
                         input logic [7:0] wdata, input logic [7:0] exp, input string tag);
      logic [7:0] got;
      if (!sel) begin
         addr4 = addr; rd4 = rd; wr4 = wr; wdata4 = wdata[3:0];
      end else begin
         addr8 = addr; rd8 = rd; wr8 = wr; wdata8 = wdata;
      end
      if (rd) exp_q.push_back(exp);
      tick();
      rd4 = 1'b0; wr4 = 1'b0; rd8 = 1'b0; wr8 = 1'b0;
      if (rd) begin
         got = sel ? rdata8 : {4'h0, rdata4};
         check(tag, 32'(got), 32'(exp_q.pop_front()));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b0;
      sw4 = 4'h0; addr4 = 1'b0; rd4 = 1'b0; wr4 = 1'b0; wdata4 = 4'h0;
      sw8 = 8'h0; addr8 = 1'b0; rd8 = 1'b0; wr8 = 1'b0; wdata8 = 8'h0;

      // Reset with switches high, then latency from release
      sw4 = 4'hF;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_leds",  32'(leds4),  32'h0);
         check("rst_rdata", 32'(rdata4), 32'h0);
         check("rst_ready", 32'(rdy4),   32'h0);
      end
      reset = 1'b1;
      ticks(6);
      check("rel_ready_e6", 32'(rdy4), 32'h0);
      tick();
      check("rel_ready_e7", 32'(rdy4), 32'h1);

      // Fresh reset with switches low
      reset = 1'b0;
      sw4 = 4'h0;
      ticks(2);
      check("rst2_ready", 32'(rdy4), 32'h0);
      reset = 1'b1;

      // Debounce latency
      sw4 = 4'h5;
      ticks(6);
      check("lat_e6", 32'(rdy4), 32'h0);
      tick();
      check("lat_e7", 32'(rdy4), 32'h1);
      bus_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h0, 8'h05, "rd_data_5");
      check("ready_clr", 32'(rdy4), 32'h0);
      tick();
      check("rdata_hold", 32'(rdata4), 32'h5);

      // Glitch shorter than the window
      sw4 = 4'hA;
      ticks(3);
      sw4 = 4'h5;
      ticks(10);
      check("glitch_ready", 32'(rdy4), 32'h0);
      bus_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h0, 8'h05, "glitch_data");

      // Flag handshake and read on the update edge
      sw4 = 4'h6;
      ticks(7);
      check("hs_ready6", 32'(rdy4), 32'h1);
      bus_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h0, 8'h06, "hs_data6");
      check("hs_clr6", 32'(rdy4), 32'h0);
      sw4 = 4'h7;
      ticks(6);
      bus_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h0, 8'h06, "edge_old");
      check("edge_ready", 32'(rdy4), 32'h1);
      bus_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h0, 8'h07, "edge_new");
      check("edge_clr", 32'(rdy4), 32'h0);

      // Overflow
      sw4 = 4'h1;
      ticks(8);
      sw4 = 4'h2;
      ticks(8);
      bus_op(1'b0, 1'b1, 1'b0, 1'b1, 8'h0, 8'h03, "ovf_st1");
      bus_op(1'b0, 1'b1, 1'b0, 1'b1, 8'h0, 8'h01, "ovf_st2");
      bus_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h0, 8'h02, "ovf_data");
      check("ovf_clr", 32'(rdy4), 32'h0);

      // LED register and mirror mode
      bus_op(1'b0, 1'b0, 1'b1, 1'b0, 8'h09, 8'h0, "wr_led");
      check("led_pre", 32'(leds4), 32'h0);
      tick();
      check("led_9", 32'(leds4), 32'h9);
      sw4 = 4'h3;
      ticks(8);
      bus_op(1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h0, "wr_mirror");
      tick();
      check("mir_3", 32'(leds4), 32'h3);
      sw4 = 4'hC;
      ticks(7);
      check("mir_lag", 32'(leds4), 32'h3);
      tick();
      check("mir_C", 32'(leds4), 32'hC);
      bus_op(1'b0, 1'b1, 1'b0, 1'b1, 8'h0, 8'h07, "mir_status");
      bus_op(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h05, "rdwr_ctrl");
      tick();
      check("led_back", 32'(leds4), 32'h9);

      // 8-bit, single-sample instance
      sw8 = 8'hA5;
      ticks(3);
      check("w8_e3", 32'(rdy8), 32'h0);
      tick();
      check("w8_e4", 32'(rdy8), 32'h1);
      bus_op(1'b1, 1'b1, 1'b0, 1'b1, 8'h0, 8'h01, "w8_status");
      bus_op(1'b1, 1'b1, 1'b0, 1'b0, 8'h0, 8'hA5, "w8_data");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
